// File: rtl/reg_file_sync.sv
// rtl/reg_file_sync.sv - 32x64 register file, one write port, two registered read ports
// Entry 31 is a hard zero; same-edge reads of the entry being written see the new value.
module reg_file_sync #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 32,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en_a,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic             rd_en_b,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic             rd_valid_a,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             rd_valid_b
);

    localparam logic [AW-1:0] XZR = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             run;
    logic             wr_ok;
    logic [WIDTH-1:0] nxt_a;
    logic [WIDTH-1:0] nxt_b;

    // run stays low for the first edge after reset release, so a request that
    // lands on the deassertion edge is ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    assign wr_ok = run && wr_en && (wr_addr != XZR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        nxt_a = mem[rd_addr_a];
        if (rd_addr_a == XZR) begin
            nxt_a = '0;
        end else if (wr_ok && (wr_addr == rd_addr_a)) begin
            nxt_a = wr_data;
        end
    end

    always_comb begin
        nxt_b = mem[rd_addr_b];
        if (rd_addr_b == XZR) begin
            nxt_b = '0;
        end else if (wr_ok && (wr_addr == rd_addr_b)) begin
            nxt_b = wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_a  <= '0;
            rd_valid_a <= 1'b0;
        end else begin
            rd_valid_a <= run && rd_en_a;
            if (run && rd_en_a) begin
                rd_data_a <= nxt_a;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_b  <= '0;
            rd_valid_b <= 1'b0;
        end else begin
            rd_valid_b <= run && rd_en_b;
            if (run && rd_en_b) begin
                rd_data_b <= nxt_b;
            end
        end
    end

endmodule

// File: doc/reg_file_sync.md
REG_FILE_SYNC -- requirements
Module: reg_file_sync

Interface
REQ-001 The block SHALL be a 32-entry x 64-bit register file with one write port and two registered read ports (A, B), the read-side counterpart to the enable-gated register stores.
REQ-002 Parameter: WIDTH, 64, data bit width of every entry and data port.
REQ-003 Parameter: DEPTH, 32, number of entries (address width log2(DEPTH) = 5).
REQ-004 Timing and reset: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  asynchronous active-low reset (0 = in reset).
REQ-007 wr_en  input  1  write strobe, sampled on rising clk.
REQ-008 wr_addr  input  5  write entry index.
REQ-009 wr_data  input  WIDTH  write value.
REQ-010 rd_en_a / rd_en_b  input  1 each  read request for port A / B.
REQ-011 rd_addr_a / rd_addr_b  input  5 each  read entry index for port A / B.
REQ-012 rd_data_a / rd_data_b  output  WIDTH each  registered read result.
REQ-013 rd_valid_a / rd_valid_b  output  1 each  one-cycle pulse marking fresh rd_data.

Function
REQ-014 Write: at a rising clk with wr_en=1 and wr_addr!=31, entry[wr_addr] SHALL take wr_data; other entries unchanged.
REQ-015 Entry 31 (XZR) SHALL always read 0; writes to address 31 SHALL be discarded.
REQ-016 Read latency: at a rising clk with rd_en_x=1, rd_data_x SHALL load the addressed value, visible one cycle after the request edge.
REQ-017 rd_valid_x SHALL be 1 for exactly the cycle following each edge where rd_en_x=1, else 0; back-to-back requests give continuous valid.
REQ-018 With rd_en_x=0, rd_data_x SHALL hold its previous value.
REQ-019 Write-first bypass: if wr_en=1, rd_en_x=1 and rd_addr_x==wr_addr!=31 on the same edge, rd_data_x SHALL load wr_data, not the old entry.
REQ-020 Bypass to address 31 SHALL NOT occur; read of 31 returns 0 even while wr_en=1, wr_addr=31.
REQ-021 Ports A and B SHALL be fully independent; both may read the same address, including the address being written.
REQ-022 No combinational path SHALL exist from any input to rd_data_x or rd_valid_x.
REQ-023 Address values 0..31 are all legal; no out-of-range condition exists.

Reset
REQ-024 reset=0 SHALL immediately (without clk) clear all 32 entries, rd_data_a, rd_data_b to 0 and rd_valid_a, rd_valid_b to 0.
REQ-025 While reset=0, writes and reads SHALL be ignored; a request on the edge coinciding with reset deassertion produces no valid pulse.
REQ-026 Reset asserted mid-operation SHALL cancel any pending valid pulse and discard the in-flight write.

Verification
REQ-027 Write 64'h0123_4567_89AB_CDEF to X5, next cycle read A at 5 -> one cycle later rd_data_a=64'h0123_4567_89AB_CDEF, rd_valid_a=1 for one cycle.
REQ-028 Write 64'd99 to X31, read B at 31 -> rd_data_b=0, rd_valid_b=1.
REQ-029 Same edge: wr_en=1, wr_addr=7, wr_data=64'd42, rd_addr_a=7, rd_addr_b=7 with X7 previously 64'd17 -> both rd_data=64'd42.
REQ-030 Read A at 3 (value 64'd25), then hold rd_en_a=0 for 3 cycles while writing X3=64'd16 -> rd_data_a stays 64'd25, rd_valid_a=0 during hold.
REQ-031 Fill X0..X30 with index+1, assert reset=0 between clk edges -> outputs 0 immediately; after release, reads of X0..X30 all return 0.
REQ-032 Random stimulus for 10k cycles against a reference array model -> every valid read matches model, including bypass and XZR cases.
